// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Serial-to-parallel frame loader in front of the 8-point FFT core's input
//   register bank. It collects one complex sample per handshake into an
//   8-slot frame buffer. It then presents the whole frame in parallel until
//   the core takes it.
//
//   Optional feature macro: FFT_LOADER_BITREV_EN
//     defined   -> sample idx is stored in slot bitrev(idx), giving the
//                  input order the decimation-in-time butterflies expect
//     undefined -> natural order, slot = idx
//   Timing and handshakes are identical in both builds.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   s_valid    input sample valid
//   s_ready    loader accepts a sample (LOAD state)
//   s_re/s_im  sample real/imag part, W-bit two's complement
//   s_last     marks the 8th sample of a frame
//   m_valid    full frame available (FULL state)
//   m_ready    FFT core takes the frame
//   m_re/m_im  frame real/imag parts, slot k at [k*W +: W]
//   frame_cnt  frames delivered, wraps 255 -> 0
//   err        one-cycle pulse on a framing error
module fft_input_loader #(
  parameter int W     = 16,
  parameter int LOG2N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_re,
  input  logic signed [W-1:0] s_im,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [8*W-1:0]      m_re,
  output logic [8*W-1:0]      m_im,
  output logic [7:0]          frame_cnt,
  output logic                err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                  state, state_nxt;
  logic [LOG2N-1:0]        idx;
  logic signed [W-1:0]     slot_re [N];
  logic signed [W-1:0]     slot_im [N];
  logic                    accept;

  // Storage slot for the idx-th sample of a frame.
  function automatic logic [LOG2N-1:0] slot_map(input logic [LOG2N-1:0] i);
    logic [LOG2N-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < LOG2N; b++) r[b] = i[LOG2N-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  assign accept = s_valid & s_ready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        s_ready = 1'b1;
        // The 8th sample always completes the frame, with or without s_last.
        if (s_valid && idx == IDX_LAST) state_nxt = FULL;
      end
      FULL: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
      for (int k = 0; k < N; k++) begin
        slot_re[k] <= '0;
        slot_im[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      err   <= 1'b0;
      if (accept) begin
        slot_re[slot_map(idx)] <= s_re;
        slot_im[slot_map(idx)] <= s_im;
        if (idx == IDX_LAST) begin
          idx <= '0;
          err <= ~s_last;          // frame still delivered, missing marker flagged
        end else if (s_last) begin
          idx <= '0;               // early marker: drop the partial frame
          err <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (m_valid && m_ready) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign m_re[k*W +: W] = slot_re[k];
    assign m_im[k*W +: W] = slot_im[k];
  end

endmodule
